fpu_op_queue: RTL

Buffered, tagged front end for the multi-cycle FPU core. It accepts operand pairs and opcodes on a valid/ready interface and holds them in a DEPTH-entry FIFO. Operations are issued one at a time to the core's start/done interface, and each result is returned with its tag on a valid/ready output. It sits between bus-side requesters and the FPU. It adds queuing, tag tracking, output back-pressure and an optional hang watchdog, none of which the bare core provides.

---
 rtl/fpu_op_queue.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_op_queue.sv
// fpu_op_queue: tagged FIFO front end that issues one operation at a time to a multi-cycle FPU core.
// Defining FPU_OPQ_TIMEOUT_EN adds a hang watchdog that completes a stuck operation with a NaN error result.
module fpu_op_queue #(
    parameter int PRECISION = 64,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRECISION-1:0]     in_a,
    input  logic [PRECISION-1:0]     in_b,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [PRECISION-1:0]     core_a,
    output logic [PRECISION-1:0]     core_b,
    output logic [1:0]               core_op,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic [PRECISION-1:0]     core_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PRECISION-1:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               out_op,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PRECISION + 2 + TAG_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [PRECISION-1:0] CANON_NAN = {1'b0, {(PRECISION-1){1'b1}}};

    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           state_q, state_d;
    logic [PRECISION-1:0] core_a_q, core_a_d, core_b_q, core_b_d;
    logic [1:0]           core_op_q, core_op_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 core_start_q, core_start_d;
    logic                 out_valid_q, out_valid_d;
    logic [PRECISION-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [1:0]           out_op_q, out_op_d;
    logic                 out_err_q, out_err_d;
    logic                 push_s, pop_s, full_s, timeout_s;
    logic [EW-1:0]        head_s;

    assign full_s = (count_q == CW'(DEPTH));
    assign push_s = in_valid && in_ready;
    assign pop_s  = (state_q == ST_IDLE) && (count_q != {CW{1'b0}});
    assign head_s = mem_q[rd_ptr_q];

`ifdef FPU_OPQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT) + 1;
    logic [WW-1:0] wdog_q, wdog_d;

    // Watchdog counts WAIT cycles of the operation currently in flight.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_ISSUE) begin
            wdog_d = {WW{1'b0}};
        end else if (state_q == ST_WAIT) begin
            wdog_d = wdog_q + WW'(1);
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wdog_q <= {WW{1'b0}};
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout_s = (state_q == ST_WAIT) && (wdog_q == WW'(TIMEOUT - 1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign timeout_s        = 1'b0;
`endif

    // FIFO pointer and occupancy update; both pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Issue FSM: operand/result registers only change on their own transitions.
    always_comb begin
        state_d      = state_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_op_d    = core_op_q;
        tag_d        = tag_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_op_d     = out_op_q;
        out_err_d    = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    {core_a_d, core_b_d, core_op_d, tag_d} = head_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done that coincides with the timeout takes precedence.
                if (core_done) begin
                    out_result_d = core_result;
                    out_tag_d    = tag_q;
                    out_op_d     = core_op_q;
                    out_err_d    = 1'b0;
                    state_d      = ST_HOLD;
                end else if (timeout_s) begin
                    out_result_d = CANON_NAN;
                    out_tag_d    = tag_q;
                    out_op_d     = core_op_q;
                    out_err_d    = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        core_start_d = (state_d == ST_ISSUE);
        out_valid_d  = (state_d == ST_HOLD);
    end

    // FIFO storage; stale entries need no reset since occupancy gates reads.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_op, in_tag};
        end
    end

    // Control and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            state_q      <= ST_IDLE;
            core_a_q     <= {PRECISION{1'b0}};
            core_b_q     <= {PRECISION{1'b0}};
            core_op_q    <= 2'b00;
            tag_q        <= {TAG_W{1'b0}};
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= {PRECISION{1'b0}};
            out_tag_q    <= {TAG_W{1'b0}};
            out_op_q     <= 2'b00;
            out_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_op_q    <= core_op_d;
            tag_q        <= tag_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_op_q     <= out_op_d;
            out_err_q    <= out_err_d;
        end
    end

    assign in_ready   = !full_s && !Reset;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_op    = core_op_q;
    assign core_start = core_start_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_op     = out_op_q;
    assign out_err    = out_err_q;
    assign count      = count_q;

endmodule
